div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand and result width.
REQ-002 Parameter ATTR_WIDTH, default 4, SHALL set the attribute bus width, which is ATTR_WIDTH+1 bits.
REQ-003 Parameter INVALID, default 0, SHALL set the bit index of the invalid flag in the attribute buses.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  in  1  SHALL request a division when high; it is sampled on the clk edge.
REQ-007 numer  in  DATA_WIDTH  SHALL carry the dividend and is captured with start.
REQ-008 denom  in  DATA_WIDTH  SHALL carry the divisor and is captured with start.
REQ-009 attr_in  in  ATTR_WIDTH+1  SHALL carry the operand attribute; bit INVALID marks an invalid operand.
REQ-010 busy  out  1  SHALL be high while an operation is in flight.
REQ-011 done  out  1  SHALL be a one-cycle pulse when the results become valid.
REQ-012 quotient  out  DATA_WIDTH  SHALL hold the registered quotient.
REQ-013 remain  out  DATA_WIDTH  SHALL hold the registered remainder.
REQ-014 attr_out  out  ATTR_WIDTH+1  SHALL carry the invalid flag at bit INVALID; all other bits SHALL be 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC, FIX.
- IDLE->CALC on start.
- CALC->FIX after exactly DATA_WIDTH iterations.
- FIX->IDLE unconditionally.
REQ-016 A start sampled in IDLE SHALL capture numer, denom and attr_in, clear the iteration counter, and enter CALC.
REQ-017 A start sampled outside IDLE SHALL be ignored, with no effect on the operation in flight.
REQ-018 CALC SHALL perform one radix-2 restoring step per cycle on magnitudes, MSB of the dividend first, using a DATA_WIDTH+1-bit partial remainder.
REQ-019 Latency SHALL be fixed at DATA_WIDTH+2 edges: done SHALL go high after the edge that completes FIX, and the start edge counts as edge 0.
REQ-020 Latency SHALL be independent of operand values, including error cases.
REQ-021 busy SHALL be high from the edge after start is accepted up to and including the done cycle; busy SHALL be low in IDLE.
REQ-022 A start asserted in the done cycle SHALL be accepted, because the FSM is in IDLE in that cycle; this gives back-to-back throughput of one result per DATA_WIDTH+2 cycles.
REQ-023 quotient, remain and attr_out SHALL update only in FIX and hold until the next FIX.
REQ-024 Divide-by-zero (denom==0) SHALL produce quotient = all ones, remain = numer, and invalid = 1.
REQ-025 invalid SHALL be the OR of the captured attr_in[INVALID], divide-by-zero, and signed overflow (REQ-030).
REQ-026 An invalid operand SHALL still run the full latency and still produce a computed result.

Reset
REQ-027 Asserting rst SHALL asynchronously force state IDLE and clear the counter and all operand registers.
REQ-028 Asserting rst SHALL asynchronously force busy=0, done=0, quotient=0, remain=0 and attr_out=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation; no done SHALL follow, and the first start after deassertion SHALL behave as from power-up.

Configuration
REQ-030 With macro DIV_SEQ_SIGNED_EN defined:
- Operands SHALL be two's complement and converted to magnitudes on capture.
- FIX SHALL negate the quotient when the operand signs differ, and negate the remainder when numer is negative.
- Overflow (numer = most-negative, denom = -1) SHALL give quotient = most-negative, remain = 0, invalid = 1.
REQ-031 Without DIV_SEQ_SIGNED_EN, operands SHALL be unsigned, there SHALL be no sign logic, and no overflow case SHALL exist.
REQ-032 The interface and the latency SHALL be identical in both builds.

Structure
REQ-033 The FSM state enum (IDLE, CALC, FIX) and the counter-width function (clog2 of DATA_WIDTH+1) SHALL live in the shared package div_pkg.
REQ-034 The combinational restoring step SHALL be the sub-module div_step.
- Inputs: partial remainder, dividend bit, divisor.
- Outputs: next partial remainder, quotient bit.

Verification
REQ-035 Verification SHALL cover the following directed scenarios with DATA_WIDTH=32:
- 100/7 -> quotient=14, remain=2, invalid=0, done exactly 34 edges after start.
- 5/0 -> quotient=0xFFFFFFFF, remain=5, invalid=1, same latency.
- attr_in[INVALID]=1 with 9/3 -> quotient=3, remain=0, invalid=1.
- start held high continuously with 8/2 then 9/4 -> results 4r0 then 2r1, the two dones 34 cycles apart, and the mid-operation start ignored.
- rst asserted at cycle 10 of 1000/3, then 6/4 -> no done for the aborted operation; 1r2 with correct latency.
- Signed build, -7/2 -> quotient=-3, remain=-1; 0x80000000/-1 -> quotient=0x80000000, remain=0, invalid=1.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_e : FSM state encoding (IDLE, CALC, FIX)
//   cnt_width() : iteration counter width, clog2(DATA_WIDTH+1)
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle of the sequential divider.
//   master : drives start, numer, denom, attr_in; observes busy, done, results
//   slave  : the divider side
interface div_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4
);
    logic                  start;
    logic [DATA_WIDTH-1:0] numer;
    logic [DATA_WIDTH-1:0] denom;
    logic [ATTR_WIDTH:0]   attr_in;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remain;
    logic [ATTR_WIDTH:0]   attr_out;

    modport master (
        output start, numer, denom, attr_in,
        input  busy, done, quotient, remain, attr_out
    );

    modport slave (
        input  start, numer, denom, attr_in,
        output busy, done, quotient, remain, attr_out
    );
endinterface

// File: rtl/div_seq_step.sv
// One radix-2 restoring division step (combinational).
//   rem_in  : current partial remainder (DATA_WIDTH+1 bits)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor magnitude
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this step
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic                  bit_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic                  q_bit
);
    logic [DATA_WIDTH+1:0] trial;

    always_comb begin
        trial = {rem_in, bit_in};
        q_bit = (trial >= {2'b00, divisor});
        // When the subtract is taken the difference is below the divisor, so
        // the low DATA_WIDTH+1 bits hold it exactly.
        rem_out = q_bit ? (trial[DATA_WIDTH:0] - {1'b0, divisor})
                        : trial[DATA_WIDTH:0];
    end
endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, fixed latency DATA_WIDTH+2 edges
// (start edge = edge 0, done valid after edge DATA_WIDTH+1).
// Optional macro: DIV_SEQ_SIGNED_EN selects two's-complement operands.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : div_seq_if.slave (start/numer/denom/attr_in in,
//         busy/done/quotient/remain/attr_out out)
module div_seq
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int INVALID    = 0
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int            CW   = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    div_state_e state, state_nxt;
    logic       accept, step_en, fix_en;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] dvd;       // dividend shifts out, quotient shifts in
    logic [DATA_WIDTH-1:0] dsr;
    logic [DATA_WIDTH:0]   prem, prem_nxt;
    logic                  q_bit;
    logic                  inv_op, dz;

    logic [DATA_WIDTH-1:0] numer_mag, denom_mag;
    logic [DATA_WIDTH-1:0] quot_nxt, rem_res;
    logic [ATTR_WIDTH:0]   attr_nxt;
    logic                  inv_nxt;

    logic                  busy_q, done_q;
    logic [DATA_WIDTH-1:0] quot_q, rem_q;
    logic [ATTR_WIDTH:0]   attr_q;

`ifdef DIV_SEQ_SIGNED_EN
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic neg_q, neg_r, ovf;

    always_comb begin
        numer_mag = bus.numer[DATA_WIDTH-1] ? -bus.numer : bus.numer;
        denom_mag = bus.denom[DATA_WIDTH-1] ? -bus.denom : bus.denom;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            neg_q <= bus.numer[DATA_WIDTH-1] ^ bus.denom[DATA_WIDTH-1];
            neg_r <= bus.numer[DATA_WIDTH-1];
            ovf   <= (bus.numer == MOST_NEG) && (bus.denom == '1);
        end
    end
`else
    always_comb begin
        numer_mag = bus.numer;
        denom_mag = bus.denom;
    end
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: control outputs
    always_comb begin
        accept  = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        case (state)
            IDLE:    accept  = bus.start;
            CALC:    step_en = 1'b1;
            FIX:     fix_en  = 1'b1;
            default: ;
        endcase
    end

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (dvd[DATA_WIDTH-1]),
        .divisor (dsr),
        .rem_out (prem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            prem   <= '0;
            inv_op <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            dvd    <= numer_mag;
            dsr    <= denom_mag;
            prem   <= '0;
            inv_op <= bus.attr_in[INVALID];
            dz     <= (bus.denom == '0);
        end else if (step_en) begin
            cnt  <= cnt + CW'(1);
            dvd  <= {dvd[DATA_WIDTH-2:0], q_bit};
            prem <= prem_nxt;
        end
    end

    // Result fix-up; the partial remainder is below the divisor, so its
    // low DATA_WIDTH bits carry the full remainder.
    always_comb begin
        quot_nxt = dvd;
        rem_res  = prem[DATA_WIDTH-1:0];
        inv_nxt  = inv_op | dz;
`ifdef DIV_SEQ_SIGNED_EN
        if (neg_q) quot_nxt = -dvd;
        if (neg_r) rem_res  = -prem[DATA_WIDTH-1:0];
        inv_nxt = inv_nxt | ovf;
`endif
        // Divide-by-zero overrides the sign fix; the remainder already
        // reproduces the dividend.
        if (dz) quot_nxt = '1;
        attr_nxt          = '0;
        attr_nxt[INVALID] = inv_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            attr_q <= '0;
        end else begin
            done_q <= fix_en;
            // busy spans the done cycle; a start accepted there keeps it high
            if (accept)      busy_q <= 1'b1;
            else if (done_q) busy_q <= 1'b0;
            if (fix_en) begin
                quot_q <= quot_nxt;
                rem_q  <= rem_res;
                attr_q <= attr_nxt;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.quotient = quot_q;
    assign bus.remain   = rem_q;
    assign bus.attr_out = attr_q;
endmodule
